// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NumQueues registered-read FIFOs into one valid/ready stream,
// tagging each word with its source queue; a 2-entry skid buffer absorbs read latency.
module fifo_rr_drain #(
    parameter int DataWidth = 32,
    parameter int NumQueues = 4,
    localparam int QidWidth = ($clog2(NumQueues) > 1) ? $clog2(NumQueues) : 1
) (
    input  logic                           clk,
    input  logic                           i_rst,
    input  logic [NumQueues-1:0]           i_q_empty,
    input  logic [NumQueues-1:0]           i_q_enable,
    output logic [NumQueues-1:0]           o_q_read,
    input  logic [NumQueues*DataWidth-1:0] i_q_read_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [DataWidth-1:0]           o_data,
    output logic [QidWidth-1:0]            o_qid
);

    logic [NumQueues-1:0] elig;
    logic                 found;
    logic [QidWidth-1:0]  gnt_idx;
    logic [QidWidth-1:0]  prio_q, prio_d;
    logic                 infl_q, infl_d;
    logic [QidWidth-1:0]  infl_qid_q, infl_qid_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0] buf_data_q [2];
    logic [QidWidth-1:0]  buf_qid_q  [2];
    logic                 wr_idx;
    logic                 pop;
    logic                 issue;
    logic [2:0]           occ;
    logic [DataWidth-1:0] cap_data;

    assign elig     = i_q_enable & ~i_q_empty;
    assign pop      = (cnt_q != 2'd0) & i_ready;
    // Credit counts the in-flight read so a word always has a slot when it lands.
    assign occ      = {1'b0, cnt_q} + {2'b0, infl_q};
    assign issue    = found & ((occ - {2'b0, pop}) < 3'd2) & ~i_rst;
    assign wr_idx   = rd_ptr_q ^ cnt_q[0];
    assign cap_data = i_q_read_data[int'(infl_qid_q)*DataWidth +: DataWidth];

    always_comb begin
        int idx;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NumQueues; k++) begin
            idx = int'(prio_q) + k;
            if (idx >= NumQueues) idx = idx - NumQueues;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                gnt_idx = QidWidth'(idx);
            end
        end
    end

    always_comb begin
        o_q_read = '0;
        if (issue) o_q_read[gnt_idx] = 1'b1;
    end

    always_comb begin
        prio_d     = prio_q;
        infl_d     = issue;
        infl_qid_d = issue ? gnt_idx : infl_qid_q;
        cnt_d      = cnt_q + {1'b0, infl_q} - {1'b0, pop};
        rd_ptr_d   = rd_ptr_q ^ pop;
        if (issue) begin
            prio_d = (gnt_idx == QidWidth'(NumQueues - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            prio_q     <= '0;
            infl_q     <= 1'b0;
            infl_qid_q <= '0;
            cnt_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_qid_q[i]  <= '0;
            end
        end else begin
            prio_q     <= prio_d;
            infl_q     <= infl_d;
            infl_qid_q <= infl_qid_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            // Capture is unconditional on i_ready; the credit check guarantees room.
            if (infl_q) begin
                buf_data_q[wr_idx] <= cap_data;
                buf_qid_q[wr_idx]  <= infl_qid_q;
            end
        end
    end

    assign o_valid = (cnt_q != 2'd0);
    assign o_data  = buf_data_q[rd_ptr_q];
    assign o_qid   = buf_qid_q[rd_ptr_q];

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain: behavioural FIFO models feed the DUT and a
// negedge collector records every accepted word for ordering/loss checks.
module tb_fifo_rr_drain;

    logic         clk;
    logic         i_rst;
    logic [3:0]   i_q_empty;
    logic [3:0]   i_q_enable;
    logic [3:0]   o_q_read;
    logic [127:0] i_q_read_data;
    logic         o_valid;
    logic         i_ready;
    logic [31:0]  o_data;
    logic [1:0]   o_qid;

    fifo_rr_drain #(.DataWidth(32), .NumQueues(4)) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_q_empty     (i_q_empty),
        .i_q_enable    (i_q_enable),
        .o_q_read      (o_q_read),
        .i_q_read_data (i_q_read_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_qid         (o_qid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: tail/mem written by the stimulus, head/rdata by the read port.
    logic [31:0] mem [4][16];
    int          head [4];
    int          tail [4];
    logic [31:0] rdata [4];

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (o_q_read[n] && head[n] != tail[n]) begin
                rdata[n] <= mem[n][head[n] % 16];
                head[n]  <= head[n] + 1;
            end
        end
    end

    always_comb begin
        i_q_empty     = '0;
        i_q_read_data = '0;
        for (int n = 0; n < 4; n++) begin
            i_q_empty[n]              = (head[n] == tail[n]);
            i_q_read_data[n*32 +: 32] = rdata[n];
        end
    end

    // Collector: accepted words, per-queue strobe counts, protocol violations.
    logic [1:0]  out_qid  [256];
    logic [31:0] out_data [256];
    int          out_cyc  [256];
    int          out_n;
    int          cyc_n;
    int          strb_cnt [4];
    int          viol;

    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (o_valid && i_ready && out_n < 256) begin
            out_qid[out_n]  <= o_qid;
            out_data[out_n] <= o_data;
            out_cyc[out_n]  <= cyc_n;
            out_n           <= out_n + 1;
        end
        for (int n = 0; n < 4; n++)
            if (o_q_read[n]) strb_cnt[n] <= strb_cnt[n] + 1;
        if (((o_q_read & i_q_empty) != 4'b0) || !$onehot0(o_q_read)) viol <= viol + 1;
    end

    int errors;
    int checks;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dval(input int tag, input int q, input int k);
        return {8'(tag), 8'(q), 16'(k)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int q, input int nw, input int tag);
        for (int k = 0; k < nw; k++) begin
            mem[q][tail[q] % 16] = dval(tag, q, k);
            tail[q]              = tail[q] + 1;
        end
    endtask

    task automatic rst_on();
        i_rst = 1'b1;
        cyc();
        for (int n = 0; n < 4; n++) tail[n] = head[n];
    endtask

    task automatic rst_off();
        cyc();
        i_rst = 1'b0;
    endtask

    task automatic wait_pops(input int target);
        for (int i = 0; i < 100 && out_n < target; i++) cyc();
        chk("pop_timeout", 64'(out_n >= target), 64'd1);
    endtask

    task automatic chk_word(input string tag, input int idx, input int q, input int k, input int t);
        chk(tag, 64'(out_qid[idx]), 64'(q));
        chk(tag, 64'(out_data[idx]), 64'(dval(t, q, k)));
    endtask

    int base;
    int snap [4];
    int exp_q [4];
    int exp_k [4];

    initial begin
        errors     = 0;
        checks     = 0;
        i_rst      = 1'b1;
        i_ready    = 1'b1;
        i_q_enable = 4'hF;
        for (int n = 0; n < 4; n++) load(n, 3, 1);

        // Reset values with every queue non-empty
        for (int i = 0; i < 2; i++) begin
            cyc();
            #2;
            chk("rst_read", 64'(o_q_read), 64'h0);
            chk("rst_valid", 64'(o_valid), 64'h0);
            chk("rst_data", 64'(o_data), 64'h0);
            chk("rst_qid", 64'(o_qid), 64'h0);
        end
        base = out_n;
        for (int n = 0; n < 4; n++) snap[n] = strb_cnt[n];
        cyc();
        i_rst = 1'b0;
        #2;
        chk("first_strobe_q0", 64'(o_q_read), 64'h1);
        chk("lat_t0_valid", 64'(o_valid), 64'h0);
        cyc();
        #2;
        chk("lat_t1_valid", 64'(o_valid), 64'h0);
        chk("second_strobe_q1", 64'(o_q_read), 64'h2);
        cyc();
        #2;
        chk("lat_t2_valid", 64'(o_valid), 64'h1);
        chk("lat_t2_qid", 64'(o_qid), 64'h0);
        chk("lat_t2_data", 64'(o_data), 64'(dval(1, 0, 0)));

        // Round-robin across four 3-deep queues at one word per cycle
        wait_pops(base + 12);
        for (int i = 0; i < 12; i++) chk_word("rr_word", base + i, i % 4, i / 4, 1);
        chk("rr_rate", 64'(out_cyc[base + 11] - out_cyc[base]), 64'd11);
        for (int n = 0; n < 4; n++) chk("rr_strobes", 64'(strb_cnt[n] - snap[n]), 64'd3);

        // Skip an empty queue (1) and a disabled queue (2)
        rst_on();
        i_q_enable = 4'b1011;
        load(0, 2, 3);
        load(2, 2, 3);
        load(3, 2, 3);
        for (int n = 0; n < 4; n++) snap[n] = strb_cnt[n];
        base = out_n;
        rst_off();
        wait_pops(base + 4);
        repeat (3) cyc();
        exp_q = '{0, 3, 0, 3};
        exp_k = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) chk_word("skip_word", base + i, exp_q[i], exp_k[i], 3);
        chk("skip_q1_strobes", 64'(strb_cnt[1] - snap[1]), 64'd0);
        chk("skip_q2_strobes", 64'(strb_cnt[2] - snap[2]), 64'd0);
        chk("skip_extra_pops", 64'(out_n - base), 64'd4);
        i_q_enable = 4'hF;

        // Backpressure: ready low for 5 cycles with 1 buffered + 1 in flight
        rst_on();
        for (int n = 0; n < 4; n++) load(n, 2, 4);
        base = out_n;
        rst_off();
        cyc();
        cyc();
        cyc();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp_no_strobe", 64'(o_q_read), 64'h0);
            chk("bp_valid", 64'(o_valid), 64'h1);
            chk("bp_head_qid", 64'(o_qid), 64'h1);
            cyc();
        end
        i_ready = 1'b1;
        #2;
        chk("bp_resume_q3", 64'(o_q_read), 64'h8);
        wait_pops(base + 8);
        repeat (3) cyc();
        for (int i = 0; i < 8; i++) chk_word("bp_word", base + i, i % 4, i / 4, 4);
        chk("bp_no_dup", 64'(out_n - base), 64'd8);

        // Wrap: prio reaches 3, single-word queue 3 read once, prio returns to 0
        rst_on();
        for (int n = 0; n < 4; n++) snap[n] = strb_cnt[n];
        base = out_n;
        rst_off();
        load(2, 1, 5);
        load(3, 1, 5);
        #2;
        chk("wrap_q2", 64'(o_q_read), 64'h4);
        cyc();
        load(0, 1, 5);
        load(1, 1, 5);
        #2;
        chk("wrap_q3_at_prio3", 64'(o_q_read), 64'h8);
        cyc();
        #2;
        chk("wrap_to_q0", 64'(o_q_read), 64'h1);
        wait_pops(base + 4);
        repeat (3) cyc();
        exp_q = '{2, 3, 0, 1};
        for (int i = 0; i < 4; i++) chk_word("wrap_word", base + i, exp_q[i], 0, 5);
        chk("wrap_q3_once", 64'(strb_cnt[3] - snap[3]), 64'd1);

        // Mid-stream reset with a word buffered and another in flight
        rst_on();
        for (int n = 0; n < 4; n++) load(n, 3, 6);
        i_ready = 1'b0;
        rst_off();
        cyc();
        #2;
        chk("mr_strobe_q1", 64'(o_q_read), 64'h2);
        cyc();
        #2;
        chk("mr_full_no_strobe", 64'(o_q_read), 64'h0);
        chk("mr_valid_before", 64'(o_valid), 64'h1);
        i_rst = 1'b1;
        cyc();
        #2;
        chk("mr_valid_cleared", 64'(o_valid), 64'h0);
        chk("mr_read_forced", 64'(o_q_read), 64'h0);
        base = out_n;
        i_rst   = 1'b0;
        i_ready = 1'b1;
        #2;
        chk("mr_restart_q0", 64'(o_q_read), 64'h1);
        wait_pops(base + 4);
        exp_q = '{0, 1, 2, 3};
        exp_k = '{1, 1, 0, 0};
        for (int i = 0; i < 4; i++) chk_word("mr_word", base + i, exp_q[i], exp_k[i], 6);

        repeat (10) cyc();
        chk("no_empty_or_multi_read", 64'(viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
